// File: rtl/uart_host_pkg.sv
// Shared definitions for the UART Wishbone host: register map, init values,
// LSR bit positions, FSM states and the request record used by the sequencer.
package uart_host_pkg;

  // UART register map on the 8-bit bus (DLAB selects DLL/DLM at 0/1)
  localparam logic [2:0] REG_RBR = 3'd0;
  localparam logic [2:0] REG_THR = 3'd0;
  localparam logic [2:0] REG_DLL = 3'd0;
  localparam logic [2:0] REG_IER = 3'd1;
  localparam logic [2:0] REG_DLM = 3'd1;
  localparam logic [2:0] REG_FCR = 3'd2;
  localparam logic [2:0] REG_LCR = 3'd3;
  localparam logic [2:0] REG_LSR = 3'd5;

  // 8N1 with DLAB set, 8N1 with DLAB clear, FIFOs enabled and cleared
  localparam logic [7:0] LCR_DLAB_8N1 = 8'h83;
  localparam logic [7:0] LCR_8N1      = 8'h03;
  localparam logic [7:0] FCR_INIT     = 8'h07;

  localparam int LSR_DR   = 0;
  localparam int LSR_THRE = 5;

  localparam logic [2:0] INIT_LAST = 3'd5;

  typedef enum logic [1:0] {
    INIT,
    POLL,
    RX_READ,
    TX_WRITE
  } host_state_t;

  typedef struct packed {
    logic       we;
    logic [2:0] adr;
    logic [7:0] dat;
  } wb_req_t;

  localparam wb_req_t LSR_REQ = '{we: 1'b0, adr: REG_LSR, dat: 8'h00};
  localparam wb_req_t RBR_REQ = '{we: 1'b0, adr: REG_RBR, dat: 8'h00};
  // THR data is taken live from the tx stream at launch; dat here is unused
  localparam wb_req_t THR_REQ = '{we: 1'b1, adr: REG_THR, dat: 8'h00};

  // Write for one step of the configuration sequence
  function automatic wb_req_t init_req(input logic [2:0] step, input logic [15:0] div);
    wb_req_t r;
    r.we = 1'b1;
    case (step)
      3'd0:    begin r.adr = REG_LCR; r.dat = LCR_DLAB_8N1; end
      3'd1:    begin r.adr = REG_DLL; r.dat = div[7:0];     end
      3'd2:    begin r.adr = REG_DLM; r.dat = div[15:8];    end
      3'd3:    begin r.adr = REG_LCR; r.dat = LCR_8N1;      end
      3'd4:    begin r.adr = REG_FCR; r.dat = FCR_INIT;     end
      default: begin r.adr = REG_IER; r.dat = 8'h00;        end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uart_wb_master_port.sv
// Single-transfer Wishbone initiator. A request is accepted when idle and
// held on the bus until ack or until the ack timeout expires. done and tout
// are combinational and mark the edge on which the cycle ends.
module uart_wb_master_port #(
  parameter int ADDR_W      = 3,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              req,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_adr,
  input  logic [7:0]        req_dat,
  output logic              busy,
  output logic              done,
  output logic              tout,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [7:0]        wb_dat_o,
  output logic              wb_we_o,
  output logic              wb_stb_o,
  output logic              wb_cyc_o,
  input  logic              wb_ack_i,
  output logic              err_o
);

  localparam int CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  assign busy = wb_stb_o;
  assign done = wb_stb_o & wb_ack_i;
  assign tout = wb_stb_o & ~wb_ack_i & (cnt == CNT_LAST);

  // Launch on request when idle; end the cycle on ack or on timeout.
  // Dropping stb on the ending edge guarantees an idle cycle before relaunch.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb_stb_o <= 1'b0;
      wb_cyc_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_adr_o <= '0;
      wb_dat_o <= 8'h00;
      cnt      <= '0;
      err_o    <= 1'b0;
    end else if (!wb_stb_o) begin
      if (req) begin
        wb_stb_o <= 1'b1;
        wb_cyc_o <= 1'b1;
        wb_we_o  <= req_we;
        wb_adr_o <= req_adr;
        wb_dat_o <= req_dat;
        cnt      <= '0;
      end
    end else if (wb_ack_i) begin
      wb_stb_o <= 1'b0;
      wb_cyc_o <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      wb_stb_o <= 1'b0;
      wb_cyc_o <= 1'b0;
      err_o    <= 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_wb_host.sv
// Configures the UART for 8N1, then polls LSR and moves bytes between the
// tx/rx streams and THR/RBR. The FSM issues one request at a time to the
// master port and picks the next request on the edge the current one ends.
module uart_wb_host
  import uart_host_pkg::*;
#(
  parameter int          ADDR_W      = 3,
  parameter logic [15:0] DIVISOR     = 16'd27,
  parameter int          ACK_TIMEOUT = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [7:0]        wb_dat_o,
  input  logic [7:0]        wb_dat_i,
  output logic              wb_we_o,
  output logic              wb_stb_o,
  output logic              wb_cyc_o,
  input  logic              wb_ack_i,
  input  logic [7:0]        tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [7:0]        rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic              init_done_o,
  output logic              err_o
);

  host_state_t state;
  logic [2:0]  step;
  logic        req_pend;
  wb_req_t     req_r;

  logic        busy, done, tout;
  logic        req;
  logic [7:0]  req_dat;

  // A THR write only launches while the source still offers a byte
  assign req     = req_pend & ((state != TX_WRITE) | tx_valid_i);
  assign req_dat = (state == TX_WRITE) ? tx_data_i : req_r.dat;

  uart_wb_master_port #(
    .ADDR_W      (ADDR_W),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_port (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .req      (req),
    .req_we   (req_r.we),
    .req_adr  (ADDR_W'(req_r.adr)),
    .req_dat  (req_dat),
    .busy     (busy),
    .done     (done),
    .tout     (tout),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_we_o  (wb_we_o),
    .wb_stb_o (wb_stb_o),
    .wb_cyc_o (wb_cyc_o),
    .wb_ack_i (wb_ack_i),
    .err_o    (err_o)
  );

  // Sequencer: init writes, LSR poll, RBR read / THR write, rx holding register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= INIT;
      step        <= 3'd0;
      req_pend    <= 1'b1;
      req_r       <= init_req(3'd0, DIVISOR);
      init_done_o <= 1'b0;
      tx_ready_o  <= 1'b0;
      rx_valid_o  <= 1'b0;
      rx_data_o   <= 8'h00;
    end else begin
      tx_ready_o <= 1'b0;
      if (rx_valid_o && rx_ready_i) rx_valid_o <= 1'b0;
      if (req && !busy) req_pend <= 1'b0;

      case (state)
        INIT: begin
          if (done) begin
            req_pend <= 1'b1;
            if (step == INIT_LAST) begin
              init_done_o <= 1'b1;
              state       <= POLL;
              req_r       <= LSR_REQ;
            end else begin
              step  <= step + 3'd1;
              req_r <= init_req(step + 3'd1, DIVISOR);
            end
          end else if (tout) begin
            req_pend <= 1'b1;  // retry the same step
          end
        end

        POLL: begin
          if (done) begin
            req_pend <= 1'b1;
            // rx first so the UART FIFO drains before it overruns
            if (wb_dat_i[LSR_DR] && !rx_valid_o) begin
              state <= RX_READ;
              req_r <= RBR_REQ;
            end else if (wb_dat_i[LSR_THRE] && tx_valid_i) begin
              state <= TX_WRITE;
              req_r <= THR_REQ;
            end else begin
              req_r <= LSR_REQ;
            end
          end else if (tout) begin
            req_pend <= 1'b1;
            req_r    <= LSR_REQ;
          end
        end

        RX_READ: begin
          if (done) begin
            rx_data_o  <= wb_dat_i;
            rx_valid_o <= 1'b1;
          end
          if (done || tout) begin
            state    <= POLL;
            req_pend <= 1'b1;
            req_r    <= LSR_REQ;
          end
        end

        TX_WRITE: begin
          if (done) tx_ready_o <= 1'b1;
          if (done || tout) begin
            state    <= POLL;
            req_pend <= 1'b1;
            req_r    <= LSR_REQ;
          end else if (req_pend && !busy && !tx_valid_i) begin
            // byte withdrawn before launch: skip the write, keep polling
            state <= POLL;
            req_r <= LSR_REQ;
          end
        end

        default: begin
          state    <= POLL;
          req_pend <= 1'b1;
          req_r    <= LSR_REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_wb_host.sv
// Directed bench for uart_wb_host: a zero-wait UART register model answers
// LSR/RBR reads from bench variables, and a monitor logs every acked transfer.
module tb_uart_wb_host;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] wb_adr;
  logic [7:0] wb_dat_o, wb_dat_i;
  logic       wb_we, wb_stb, wb_cyc;
  logic       wb_ack = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       init_done, err;

  logic [7:0] lsr_val = 8'h00;
  logic [7:0] rbr_val = 8'h00;
  logic       block_dll = 1'b0;

  logic [10:0] wr_q[$];   // {adr, dat} of acked writes
  logic [3:0]  ord_q[$];  // {we, adr} of every acked transfer
  int n_rbr = 0;
  int n_txr = 0;
  int n_chk = 0;
  int n_pass = 0;

  uart_wb_host #(.ADDR_W(3), .DIVISOR(16'h1234), .ACK_TIMEOUT(8)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wb_adr_o    (wb_adr),
    .wb_dat_o    (wb_dat_o),
    .wb_dat_i    (wb_dat_i),
    .wb_we_o     (wb_we),
    .wb_stb_o    (wb_stb),
    .wb_cyc_o    (wb_cyc),
    .wb_ack_i    (wb_ack),
    .tx_data_i   (tx_data),
    .tx_valid_i  (tx_valid),
    .tx_ready_o  (tx_ready),
    .rx_data_o   (rx_data),
    .rx_valid_o  (rx_valid),
    .rx_ready_i  (rx_ready),
    .init_done_o (init_done),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  assign wb_dat_i = (wb_adr == 3'd5) ? lsr_val : (wb_adr == 3'd0) ? rbr_val : 8'h00;

  // ack one cycle after stb; optionally ignore DLL/THR writes
  always @(posedge clk) begin
    if (rst) wb_ack <= 1'b0;
    else wb_ack <= wb_stb && wb_cyc && !wb_ack && !(block_dll && wb_we && wb_adr == 3'd0);
  end

  always @(posedge clk) begin
    if (!rst) begin
      if (wb_stb && wb_ack) begin
        ord_q.push_back({wb_we, wb_adr});
        if (wb_we) wr_q.push_back({wb_adr, wb_dat_o});
        else if (wb_adr == 3'd0) n_rbr++;
      end
      if (tx_ready) n_txr++;
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({wb_stb, wb_cyc, wb_we, wb_adr, wb_dat_o} !== '0)
      $display("FAIL reset_wb got %h want 0", {wb_stb, wb_cyc, wb_we, wb_adr, wb_dat_o});
    else n_pass++;
    n_chk++;
    if ({tx_ready, rx_valid, rx_data, init_done, err} !== '0)
      $display("FAIL reset_stream got %h want 0", {tx_ready, rx_valid, rx_data, init_done, err});
    else n_pass++;
  endtask

  task automatic test_init();
    logic [10:0] exp [6];
    int b, t;
    exp = '{{3'd3, 8'h83}, {3'd0, 8'h34}, {3'd1, 8'h12}, {3'd3, 8'h03}, {3'd2, 8'h07}, {3'd1, 8'h00}};
    b = wr_q.size();
    rst = 1'b0;
    t = 0;
    while (!init_done && t < 200) begin @(negedge clk); t++; end
    n_chk++;
    if (!init_done) $display("FAIL init_wait got init_done=0 want 1 within 200 cycles"); else n_pass++;
    n_chk++;
    if (wr_q.size() - b != 6) $display("FAIL init_count got %0d want 6", wr_q.size() - b); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      n_chk++;
      if (wr_q.size() <= b + i || wr_q[b + i] !== exp[i])
        $display("FAIL init_wr%0d got %h want %h", i, (wr_q.size() > b + i) ? wr_q[b + i] : 11'h0, exp[i]);
      else n_pass++;
    end
    n_chk++;
    if (err !== 1'b0) $display("FAIL init_err got %b want 0", err); else n_pass++;
  endtask

  task automatic test_tx();
    int b, r, t;
    b = wr_q.size();
    r = n_txr;
    lsr_val = 8'h20; tx_data = 8'hA5; tx_valid = 1'b1;
    t = 0;
    while (!tx_ready && t < 50) begin @(negedge clk); t++; end
    tx_valid = 1'b0;
    n_chk++;
    if (!tx_ready) $display("FAIL tx_wait got tx_ready=0 want 1 within 50 cycles"); else n_pass++;
    n_chk++;
    if (wr_q.size() != b + 1 || wr_q[b] !== {3'd0, 8'hA5})
      $display("FAIL tx_thr got n=%0d want n=1 with 0a5", wr_q.size() - b);
    else n_pass++;
    repeat (10) @(negedge clk);
    n_chk++;
    if (n_txr - r != 1) $display("FAIL tx_pulse got %0d pulses want 1", n_txr - r); else n_pass++;
    lsr_val = 8'h00; tx_data = 8'h3C; tx_valid = 1'b1;
    repeat (30) @(negedge clk);
    n_chk++;
    if (wr_q.size() != b + 1) $display("FAIL tx_hold got %0d writes want 1", wr_q.size() - b); else n_pass++;
    lsr_val = 8'h20;
    t = 0;
    while (!tx_ready && t < 50) begin @(negedge clk); t++; end
    tx_valid = 1'b0;
    n_chk++;
    if (wr_q.size() != b + 2 || wr_q[b + 1] !== {3'd0, 8'h3C})
      $display("FAIL tx_second got n=%0d want n=2 with 03c", wr_q.size() - b);
    else n_pass++;
  endtask

  task automatic test_rx_backpressure();
    int b, rb, t;
    b = wr_q.size();
    rb = n_rbr;
    rx_ready = 1'b0; rbr_val = 8'h5A; lsr_val = 8'h21;
    t = 0;
    while (!rx_valid && t < 50) begin @(negedge clk); t++; end
    n_chk++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h5A)
      $display("FAIL rx_load got v=%b d=%h want v=1 d=5a", rx_valid, rx_data);
    else n_pass++;
    tx_data = 8'h77; tx_valid = 1'b1;
    t = 0;
    while (!tx_ready && t < 50) begin @(negedge clk); t++; end
    tx_valid = 1'b0;
    n_chk++;
    if (wr_q.size() != b + 1 || wr_q[b] !== {3'd0, 8'h77})
      $display("FAIL rx_txpass got n=%0d want n=1 with 077", wr_q.size() - b);
    else n_pass++;
    repeat (20) @(negedge clk);
    n_chk++;
    if (n_rbr - rb != 1 || rx_valid !== 1'b1 || rx_data !== 8'h5A)
      $display("FAIL rx_hold got reads=%0d v=%b d=%h want reads=1 v=1 d=5a", n_rbr - rb, rx_valid, rx_data);
    else n_pass++;
    rbr_val = 8'h6B; rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    n_chk++;
    if (rx_valid !== 1'b0) $display("FAIL rx_accept got v=%b want 0", rx_valid); else n_pass++;
    t = 0;
    while (!rx_valid && t < 50) begin @(negedge clk); t++; end
    n_chk++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h6B || n_rbr - rb != 2)
      $display("FAIL rx_reload got v=%b d=%h reads=%0d want v=1 d=6b reads=2", rx_valid, rx_data, n_rbr - rb);
    else n_pass++;
    lsr_val = 8'h00;
    repeat (6) @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic test_priority();
    int ob, ri, wi, t;
    ob = ord_q.size();
    rbr_val = 8'hC3; tx_data = 8'h99; tx_valid = 1'b1; lsr_val = 8'h21;
    t = 0;
    while (!tx_ready && t < 60) begin @(negedge clk); t++; end
    tx_valid = 1'b0; lsr_val = 8'h00;
    ri = -1; wi = -1;
    for (int i = ob; i < ord_q.size(); i++) begin
      if (ri < 0 && ord_q[i] == 4'b0000) ri = i;
      if (wi < 0 && ord_q[i] == 4'b1000) wi = i;
    end
    n_chk++;
    if (ri < 0 || wi < 0 || wi < ri) $display("FAIL prio_order got rbr@%0d thr@%0d want rbr before thr", ri, wi);
    else n_pass++;
    n_chk++;
    if (rx_valid !== 1'b1 || rx_data !== 8'hC3)
      $display("FAIL prio_rx got v=%b d=%h want v=1 d=c3", rx_valid, rx_data);
    else n_pass++;
    repeat (4) @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int b, t, n;
    bit run;
    rst = 1'b1; block_dll = 1'b1; lsr_val = 8'h00;
    repeat (2) @(negedge clk);
    b = wr_q.size();
    rst = 1'b0;
    t = 0;
    while (!(wb_stb && wb_we && wb_adr == 3'd0) && t < 60) begin @(negedge clk); t++; end
    n_chk++;
    if (!(wb_stb && wb_we && wb_adr == 3'd0) || err !== 1'b0)
      $display("FAIL to_start got stb=%b adr=%0d err=%b want stb=1 adr=0 err=0", wb_stb, wb_adr, err);
    else n_pass++;
    n = 1; run = 1'b1;
    while (run && n < 20) begin
      @(negedge clk);
      if (wb_stb) n++; else run = 1'b0;
    end
    n_chk++;
    if (n != 8) $display("FAIL to_len got %0d cycles want 8", n); else n_pass++;
    n_chk++;
    if (err !== 1'b1 || wb_cyc !== 1'b0) $display("FAIL to_err got err=%b cyc=%b want err=1 cyc=0", err, wb_cyc);
    else n_pass++;
    t = 0;
    while (!wb_stb && t < 5) begin @(negedge clk); t++; end
    n_chk++;
    if ({wb_stb, wb_we, wb_adr, wb_dat_o} !== {1'b1, 1'b1, 3'd0, 8'h34})
      $display("FAIL to_retry got %h want %h", {wb_stb, wb_we, wb_adr, wb_dat_o}, {1'b1, 1'b1, 3'd0, 8'h34});
    else n_pass++;
    block_dll = 1'b0;
    t = 0;
    while (!init_done && t < 100) begin @(negedge clk); t++; end
    n_chk++;
    if (!init_done || wr_q.size() - b != 6 || wr_q[b + 1] !== {3'd0, 8'h34})
      $display("FAIL to_recover got done=%b writes=%0d want done=1 writes=6", init_done, wr_q.size() - b);
    else n_pass++;
    n_chk++;
    if (err !== 1'b1) $display("FAIL to_sticky got err=%b want 1", err); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int t;
    lsr_val = 8'h00;
    t = 0;
    while (!wb_stb && t < 20) begin @(negedge clk); t++; end
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({wb_stb, wb_cyc, wb_we, wb_adr, wb_dat_o, tx_ready, rx_valid, rx_data, init_done, err} !== '0)
      $display("FAIL mid_reset got stb=%b cyc=%b done=%b err=%b want all 0", wb_stb, wb_cyc, init_done, err);
    else n_pass++;
    rst = 1'b0;
    t = 0;
    while (!wb_stb && t < 10) begin @(negedge clk); t++; end
    n_chk++;
    if ({wb_stb, wb_we, wb_adr, wb_dat_o} !== {1'b1, 1'b1, 3'd3, 8'h83})
      $display("FAIL mid_restart got %h want %h", {wb_stb, wb_we, wb_adr, wb_dat_o}, {1'b1, 1'b1, 3'd3, 8'h83});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_init();
    test_tx();
    test_rx_backpressure();
    test_priority();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish want finish before 200000");
    $fatal(1, "bench stalled");
  end

endmodule
